// File: rtl/riscv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the RV32I multicycle controller:
//   - state_t   : 4-bit FSM state encoding (also exported on state_o)
//   - OP_*      : RV32I major opcodes the controller supports
//   - ALU_OP_*  : class code handed to the existing ALU decoder
//   - RES_*, SRC_A_*, SRC_B_* : datapath mux select codes
//   - ctrl_t    : packed control word driven onto the datapath
// -----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ITYPE = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
  } ctrl_t;

  // True for every opcode that has a state path; anything else is illegal.
  function automatic logic is_legal_op(logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
           (op == OP_I)    || (op == OP_BEQ)   || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the multicycle controller and the shared datapath.
//   master : controller side (samples opcode/zero/mem_ready, drives controls)
//   slave  : datapath side
// Signals:
//   opcode, zero, mem_ready             datapath/memory -> controller
//   pc_write, adr_src, mem_write,
//   ir_write, result_src, alu_src_a,
//   alu_src_b, alu_op, reg_write        controller -> datapath
//   illegal_instr, state_o, instret     controller status/debug
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             adr_src;
  logic             mem_write;
  logic             ir_write;
  logic [1:0]       result_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_write;
  logic             illegal_instr;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write,
           illegal_instr, state_o, instret
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, reg_write,
           illegal_instr, state_o, instret
  );
endinterface

// File: rtl/multicycle_out_decode.sv
// -----------------------------------------------------------------------------
// multicycle_out_decode
// Combinational state -> control word decode for the multicycle controller.
// Ports:
//   state      in   current FSM state
//   zero       in   ALU zero flag (qualifies the branch PC write)
//   mem_ready  in   memory handshake (qualifies the fetch enables)
//   ctrl       out  datapath control word
// -----------------------------------------------------------------------------
module multicycle_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave
    // a control bit unassigned and infer a latch.
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // PC+4 is formed on the ALU and written straight back to PC;
        // IR/PC only move once memory actually delivers the instruction.
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRC_A_PC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Branch target OldPC + imm is parked in ALUOut for BEQ.
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        // Strobe is held for the whole access, including the ready cycle.
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_OP_RTYPE;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ITYPE;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRC_A_RS1;
        ctrl.alu_src_b  = SRC_B_RS2;
        ctrl.alu_op     = ALU_OP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
      end
      S_JAL: begin
        // PC <= ALUOut (jump target from DECODE) while the ALU forms
        // OldPC + 4 for the link write in ALUWB.
        ctrl.alu_src_a  = SRC_A_OLDPC;
        ctrl.alu_src_b  = SRC_B_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore FSM sequencing the shared RV32I multicycle datapath (single memory
// port, one ALU, IR/ALUOut/Data registers). Decodes the opcode in DECODE,
// walks the per-class state path, waits on the memory ready handshake and
// counts retired instructions.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; forces every output to 0
//   bus    master side of multicycle_control_if (opcode/zero/mem_ready in,
//          datapath controls, illegal_instr, state_o, instret out)
// Parameters:
//   CNT_W  width of the wrapping retired-instruction counter
// -----------------------------------------------------------------------------
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] instret_q;
  ctrl_t            ctrl;
  logic             illegal;
  logic             retire;

  // ---------------------------------------------------------------------------
  // State register and retired-instruction counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. opcode is only consulted from DECODE onward, where IR
  // is stable because ir_write is confined to FETCH.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (bus.opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Illegal opcodes retire in DECODE; JAL retires later in ALUWB.
  assign illegal = (state_q == S_DECODE) && !is_legal_op(bus.opcode);
  assign retire  = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                   (state_q == S_BEQ)   || illegal ||
                   ((state_q == S_MEMWRITE) && bus.mem_ready);

  multicycle_out_decode u_out_decode (
    .state     (state_q),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // ---------------------------------------------------------------------------
  // Output stage: reset overrides the state decode so no write strobe can
  // escape in the cycle reset is sampled, even mid-instruction.
  // ---------------------------------------------------------------------------
  assign bus.pc_write      = !reset && ctrl.pc_write;
  assign bus.adr_src       = !reset && ctrl.adr_src;
  assign bus.mem_write     = !reset && ctrl.mem_write;
  assign bus.ir_write      = !reset && ctrl.ir_write;
  assign bus.reg_write     = !reset && ctrl.reg_write;
  assign bus.result_src    = reset ? 2'b00 : ctrl.result_src;
  assign bus.alu_src_a     = reset ? 2'b00 : ctrl.alu_src_a;
  assign bus.alu_src_b     = reset ? 2'b00 : ctrl.alu_src_b;
  assign bus.alu_op        = reset ? 2'b00 : ctrl.alu_op;
  assign bus.illegal_instr = !reset && illegal;
  assign bus.state_o       = reset ? 4'd0 : state_q;
  assign bus.instret       = reset ? '0 : instret_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared RV32I multicycle datapath: one memory port, one ALU, IR/ALUOut/Data registers.
- Decodes opcode in the Decode state and steps through the per-class state path.
- Handles a memory ready handshake and counts retired instructions.
- Replaces the single-cycle decoder when the core runs in multicycle mode; alu_op feeds the existing ALU decoder unchanged (00 add, 01 sub/branch, 10 R-type funct, 11 I-type funct).

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high
opcode  in  7  instr[6:0] from IR, valid from Decode onward
zero  in  1  ALU zero flag, sampled in BEQ state
mem_ready  in  1  unified memory completes the current access this cycle
pc_write  out  1  PC register enable
adr_src  out  1  memory address select: 0 PC, 1 ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR and OldPC enable
result_src  out  2  00 ALUOut, 01 Data, 10 ALU result
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
alu_op  out  2  ALU decoder class
reg_write  out  1  register file write enable
illegal_instr  out  1  one-cycle pulse, unsupported opcode in Decode
state_o  out  4  current state encoding, debug
instret  out  CNT_W  retired-instruction count

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Encoding 0..10 in the listed order, presented on state_o.
- Reset: state<=FETCH, instret<=0. While reset=1, all outputs are forced to 0, overriding state decode.
- Outputs not listed for a state are 0.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - mem_ready=1 -> DECODE; mem_ready=0 -> stay, no enables.
- DECODE: a=01, b=01, alu_op=00 (computes branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other opcode -> FETCH, with illegal_instr=1 and instret+1.
- MEMADR: a=10, b=01, alu_op=00. Next state: opcode 0000011 -> MEMREAD, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Leaves for MEMWB only when mem_ready=1, else holds.
- MEMWB: result_src=01, reg_write=1; then FETCH.
- MEMWRITE: adr_src=1, result_src=00.
  - mem_write=1 held every cycle until mem_ready=1.
  - Then FETCH.
- EXECR: a=10, b=00, alu_op=10 -> ALUWB.
- EXECI: a=10, b=01, alu_op=11 -> ALUWB.
- ALUWB: result_src=00, reg_write=1; then FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero; then FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 (PC<=ALUOut target); then ALUWB (rd<=PC+4).
- Latency with mem_ready tied 1: lw 5 cycles; sw, R, I, jal 4; beq 3; illegal opcode 2.
- instret increments by 1 on the final cycle of each instruction: MEMWB, MEMWRITE&&mem_ready, ALUWB, BEQ, illegal DECODE. The JAL cycle does not increment (JAL retires in ALUWB).
- instret wraps modulo 2^CNT_W, with no saturation.
- opcode is not resampled mid-path: it comes from IR, and IR changes only via ir_write in FETCH.
- Reset asserted mid-instruction: the next state is FETCH regardless, and no write strobe is asserted in the reset cycle.
- Unreachable state encodings (11..15) -> FETCH, with outputs 0.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum (4-bit);
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALU_OP_ADD/SUB/RTYPE/ITYPE;
  - select constants for result_src, alu_src_a and alu_src_b.
- One sub-module, multicycle_out_decode: combinational state-to-control-word decode, instantiated inside multicycle_control.
- The next-state logic, instret counter and reset override remain in multicycle_control.

Test Plan:
- reset=1 for 2 cycles mid-MEMWRITE -> all outputs 0 during reset; state_o=0 (FETCH) after release; instret=0.
- mem_ready=1, opcode=0110011 -> state_o sequence 0,1,6,8,0; reg_write=1 only in ALUWB; alu_op=10 in EXECR; instret=1.
- opcode=0000011, mem_ready low 3 cycles in MEMREAD -> state_o holds 3 for 4 cycles, then 4 (MEMWB) with result_src=01, reg_write=1.
- opcode=0100011, mem_ready=0 in FETCH for 2 cycles -> ir_write=0 and pc_write=0 while waiting; MEMWRITE has mem_write=1 for exactly 1 cycle with ready=1.
- opcode=1100011 -> zero=1: pc_write=1 in BEQ. zero=0: pc_write=0. Both retire in 3 cycles.
- opcode=1101111 -> FETCH, DECODE, JAL (pc_write=1, a=01, b=10), ALUWB (reg_write=1); instret+1 only once. Then opcode=1111111 -> illegal_instr pulses 1 cycle, back to FETCH.
